// File: rtl/intr_ctrl_pkg.sv
// Shared types and constants for the single-level interrupt controller.
package intr_ctrl_pkg;

   localparam int INTR_NUM_SRC = 4;
   localparam int SRC_UART_RX  = 0;
   localparam int SRC_TIMER    = 1;

   typedef enum logic [1:0] {
      INTR_IDLE,
      INTR_REQ,
      INTR_SERVICE
   } intr_state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder: reports whether any bit is set and the
// index of the lowest one.
module intr_prio_enc
   import intr_ctrl_pkg::*;
#(
   parameter int NUM_SRC = INTR_NUM_SRC,
   parameter int ID_W    = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] eligible,
   output logic               valid,
   output logic [ID_W-1:0]    id
);

   always_comb begin
      // NOTE: every output gets a default before any conditional assignment so no latch is inferred.
      valid = 1'b0;
      id    = '0;
      // Scanning downward lets the lowest set index overwrite the others.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            valid = 1'b1;
            id    = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches source events, masks them, raises one
// fixed-priority request and holds off further requests until IRET.
module intr_ctrl
   import intr_ctrl_pkg::*;
#(
   parameter int NUM_SRC = INTR_NUM_SRC,
   parameter int ID_W    = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               w_intr,
   input  logic               w_intr_sel,
   input  logic [31:0]        w_intr_data,
   input  logic               intr_ack,
   input  logic [31:0]        pc_next,
   input  logic               iret,
   output logic               intr_req,
   output logic [ID_W-1:0]    intr_id,
   output logic [31:0]        intr_handler,
   output logic [31:0]        epc,
   output logic               in_service
);

   intr_state_t        state, state_nxt;
   logic [NUM_SRC-1:0] pending, mask, eligible, clr;
   logic [ID_W-1:0]    id, win_id;
   logic [31:0]        handler;
   logic               win_valid, accept;

   assign eligible = pending & mask;

   intr_prio_enc #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_prio_enc (
      .eligible (eligible),
      .valid    (win_valid),
      .id       (win_id)
   );

   assign accept = (state == INTR_REQ) && intr_ack;
   assign clr    = accept ? (NUM_SRC'(1) << id) : '0;

   always_comb begin
      state_nxt = state;
      unique case (state)
         INTR_IDLE:    if (win_valid) state_nxt = INTR_REQ;
         // A request withdrawn by masking falls back to IDLE to re-arbitrate.
         INTR_REQ: begin
            if (intr_ack)            state_nxt = INTR_SERVICE;
            else if (!eligible[id])  state_nxt = INTR_IDLE;
         end
         INTR_SERVICE: if (iret) state_nxt = INTR_IDLE;
         default:      state_nxt = INTR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= INTR_IDLE;
         pending <= '0;
         mask    <= '0;
         handler <= '0;
         epc     <= '0;
         id      <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state   <= state_nxt;
         // A source high in its own clear cycle keeps its pending bit set.
         pending <= (pending & ~clr) | irq_src;
         if (w_intr && !w_intr_sel) handler <= w_intr_data;
         if (w_intr &&  w_intr_sel) mask    <= w_intr_data[NUM_SRC-1:0];
         if (accept) epc <= pc_next;
         if (state == INTR_IDLE && win_valid) id <= win_id;
      end
   end

   assign intr_req     = (state == INTR_REQ);
   assign in_service   = (state == INTR_SERVICE);
   assign intr_id      = id;
   assign intr_handler = handler;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios then random traffic,
// all compared every cycle against a behavioural model of the controller.
module tb_intr_ctrl;

   localparam int N = 4;
   localparam int S_IDLE = 0;
   localparam int S_REQ  = 1;
   localparam int S_SVC  = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  irq_src;
   logic          w_intr, w_intr_sel;
   logic [31:0]   w_intr_data;
   logic          intr_ack;
   logic [31:0]   pc_next;
   logic          iret;
   logic          intr_req;
   logic [1:0]    intr_id;
   logic [31:0]   intr_handler, epc;
   logic          in_service;

   int checks = 0;
   int errors = 0;

   int          m_state, m_id;
   bit          m_pending[N];
   bit          m_mask[N];
   logic [31:0] m_handler, m_epc;

   always #5 clk = ~clk;

   intr_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .irq_src      (irq_src),
      .w_intr       (w_intr),
      .w_intr_sel   (w_intr_sel),
      .w_intr_data  (w_intr_data),
      .intr_ack     (intr_ack),
      .pc_next      (pc_next),
      .iret         (iret),
      .intr_req     (intr_req),
      .intr_id      (intr_id),
      .intr_handler (intr_handler),
      .epc          (epc),
      .in_service   (in_service)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state   = S_IDLE;
      m_id      = 0;
      m_handler = '0;
      m_epc     = '0;
      for (int i = 0; i < N; i++) begin
         m_pending[i] = 1'b0;
         m_mask[i]    = 1'b0;
      end
   endtask

   function automatic logic [N-1:0] pend_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_pending[i];
      return v;
   endfunction

   task automatic compare_all(input string tag);
      check({tag, ".intr_req"},     intr_req,     m_state == S_REQ);
      check({tag, ".in_service"},   in_service,   m_state == S_SVC);
      check({tag, ".intr_id"},      intr_id,      m_id);
      check({tag, ".intr_handler"}, intr_handler, m_handler);
      check({tag, ".epc"},          epc,          m_epc);
      check({tag, ".pending"},      dut.pending,  pend_vec());
   endtask

   task automatic clear_pulses();
      irq_src  = '0;
      w_intr   = 1'b0;
      intr_ack = 1'b0;
      iret     = 1'b0;
   endtask

   // One clock: predict the next state from the current inputs, advance, compare.
   task automatic cycle();
      int          n_state, n_id, win;
      bit          n_pending[N];
      bit          n_mask[N];
      bit          elig[N];
      logic [31:0] n_handler, n_epc;
      win = -1;
      for (int i = 0; i < N; i++) begin
         elig[i] = m_pending[i] && m_mask[i];
         if (elig[i] && win < 0) win = i;
      end
      n_state = m_state; n_id = m_id; n_pending = m_pending; n_mask = m_mask;
      n_handler = m_handler; n_epc = m_epc;
      case (m_state)
         S_IDLE: if (win >= 0) begin n_state = S_REQ; n_id = win; end
         S_REQ: begin
            if (intr_ack) begin
               n_state = S_SVC; n_epc = pc_next; n_pending[m_id] = 1'b0;
            end else if (!elig[m_id]) n_state = S_IDLE;
         end
         S_SVC: if (iret) n_state = S_IDLE;
         default: ;
      endcase
      for (int i = 0; i < N; i++) if (irq_src[i]) n_pending[i] = 1'b1;
      if (w_intr) begin
         if (w_intr_sel) for (int i = 0; i < N; i++) n_mask[i] = w_intr_data[i];
         else n_handler = w_intr_data;
      end
      @(posedge clk);
      #1;
      m_state = n_state; m_id = n_id; m_pending = n_pending; m_mask = n_mask;
      m_handler = n_handler; m_epc = n_epc;
      compare_all("cyc");
      clear_pulses();
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic wr(input logic sel, input logic [31:0] data);
      w_intr = 1'b1; w_intr_sel = sel; w_intr_data = data;
      cycle();
   endtask

   task automatic irq(input logic [N-1:0] v);
      irq_src = v;
      cycle();
   endtask

   initial begin
      reset = 1'b1; clear_pulses(); w_intr_sel = 1'b0; w_intr_data = '0; pc_next = '0;
      model_reset();
      #2 reset = 1'b0;
      #1 compare_all("reset");
      @(posedge clk); #1;
      compare_all("reset_hold");
      #6 reset = 1'b1;

      // Single source with the documented latency.
      wr(1'b1, 32'h0000_0002);
      wr(1'b0, 32'h0000_1000);
      idle(2);
      irq(4'b0010);
      check("t1_no_req_yet", intr_req, 1'b0);
      cycle();
      check("t1_req", intr_req, 1'b1);
      check("t1_id", intr_id, 32'd1);
      idle(1);
      intr_ack = 1'b1; pc_next = 32'h0000_0040;
      cycle();
      check("t1_epc", epc, 32'h0000_0040);
      check("t1_in_service", in_service, 1'b1);
      check("t1_req_dropped", intr_req, 1'b0);
      check("t1_pending1_clear", dut.pending[1], 1'b0);
      idle(2);
      iret = 1'b1;
      cycle();
      check("t1_iret", in_service, 1'b0);
      idle(1);

      // Priority between two simultaneous sources.
      wr(1'b1, 32'h0000_000F);
      irq(4'b1010);
      cycle();
      check("t2_first_id", intr_id, 32'd1);
      check("t2_first_req", intr_req, 1'b1);
      intr_ack = 1'b1; pc_next = 32'h0000_0100;
      cycle();
      iret = 1'b1;
      cycle();
      check("t2_gap_no_req", intr_req, 1'b0);
      cycle();
      check("t2_second_req", intr_req, 1'b1);
      check("t2_second_id", intr_id, 32'd3);
      intr_ack = 1'b1; pc_next = 32'h0000_0104;
      cycle();
      iret = 1'b1;
      cycle();
      idle(1);

      // Masked source is held until the mask is opened.
      wr(1'b1, 32'h0);
      irq(4'b0100);
      idle(3);
      check("t3_masked", intr_req, 1'b0);
      wr(1'b1, 32'h0000_0004);
      check("t3_one_after_write", intr_req, 1'b0);
      cycle();
      check("t3_two_after_write", intr_req, 1'b1);
      check("t3_id", intr_id, 32'd2);
      intr_ack = 1'b1;
      cycle();
      iret = 1'b1;
      cycle();

      // Mask cleared while requesting withdraws the request, pending stays.
      wr(1'b1, 32'h0000_0001);
      irq(4'b0001);
      cycle();
      check("t4_req", intr_req, 1'b1);
      check("t4_id", intr_id, 32'd0);
      wr(1'b1, 32'h0);
      cycle();
      check("t4_withdrawn", intr_req, 1'b0);
      check("t4_pending0", dut.pending[0], 1'b1);

      // Set wins over clear in the acceptance cycle.
      wr(1'b1, 32'h0000_0001);
      cycle();
      check("t5_req", intr_req, 1'b1);
      intr_ack = 1'b1; irq_src = 4'b0001; pc_next = 32'h0000_0080;
      cycle();
      check("t5_pending0_kept", dut.pending[0], 1'b1);
      check("t5_in_service", in_service, 1'b1);
      iret = 1'b1;
      cycle();
      cycle();
      check("t5_rereq", intr_req, 1'b1);
      check("t5_rereq_id", intr_id, 32'd0);

      // Asynchronous reset while a handler runs.
      intr_ack = 1'b1; pc_next = 32'h0000_0200;
      cycle();
      check("t6_in_service", in_service, 1'b1);
      check("t6_epc", epc, 32'h0000_0200);
      #2 reset = 1'b0;
      #1 model_reset();
      compare_all("t6_async");
      check("t6_epc_lost", epc, 32'h0);
      @(posedge clk);
      #3 reset = 1'b1;
      idle(3);
      check("t6_quiet", intr_req, 1'b0);
      wr(1'b1, 32'h0000_0001);
      idle(2);
      check("t6_mask_only", intr_req, 1'b0);
      irq(4'b0001);
      cycle();
      check("t6_new_req", intr_req, 1'b1);
      intr_ack = 1'b1;
      cycle();
      iret = 1'b1;
      cycle();

      // Random traffic, including stray ack/iret that must be ignored.
      for (int k = 0; k < 400; k++) begin
         irq_src = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
         if ($urandom_range(0, 9) == 0) begin
            w_intr = 1'b1; w_intr_sel = 1'($urandom_range(0, 1)); w_intr_data = $urandom;
         end
         intr_ack = (m_state == S_REQ) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         iret     = ($urandom_range(0, 5) == 0);
         pc_next  = $urandom;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller between the CPU core and its interrupt sources (UART receive, timer compare, spares). It latches source events into pending bits and masks them with an enable register written by W_INTR. It presents one fixed-priority request to the CPU and saves the return PC on acceptance. It blocks further requests until IRET, giving single-level, non-nested interrupts.

## Interface
Parameters:
- NUM_SRC, 4, number of interrupt sources; index 0 has highest priority.
- ID_W, $clog2(NUM_SRC), width of the source id.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; all registers are cleared while it is low.
- irq_src  in  NUM_SRC  event from each source; a bit sets its pending bit in every cycle it is high.
- w_intr  in  1  W_INTR executes this cycle.
- w_intr_sel  in  1  0 = write handler address; 1 = write enable mask.
- w_intr_data  in  32  write data; mask uses bits [NUM_SRC-1:0].
- intr_ack  in  1  CPU redirected to the handler this cycle; valid only while intr_req=1.
- pc_next  in  32  return address; sampled when intr_ack=1.
- iret  in  1  IRET executes this cycle.
- intr_req  out  1  request to the CPU to take an interrupt.
- intr_id  out  ID_W  id of the requested or in-service source.
- intr_handler  out  32  handler address register.
- epc  out  32  saved return address; the CPU jumps here on IRET.
- in_service  out  1  a handler is running.

## Operation
- Registers: pending[NUM_SRC], mask[NUM_SRC], handler[32], epc[32], id[ID_W], state.
- Pending update: pending <= (pending & ~clr) | irq_src.
  - clr is the one-hot of id, and only in the cycle of acceptance.
  - If a source is high in the same cycle its bit is cleared, the set wins.
- Writes:
  - w_intr with sel=0: handler <= w_intr_data.
  - w_intr with sel=1: mask <= w_intr_data[NUM_SRC-1:0].
  - Writes are accepted in every state.
- Eligible vector: eligible = pending & mask. The winner is the lowest set index of eligible.
- State machine (INTR_STATE):
  - IDLE: intr_req=0, in_service=0. If eligible≠0, go to REQ and latch id <= winner.
  - REQ: intr_req=1, and id is frozen.
    - On intr_ack: epc <= pc_next, clear pending[id], go to SERVICE.
    - Else, if eligible[id]=0 (the mask was cleared by W_INTR): go to IDLE.
  - SERVICE: intr_req=0, in_service=1. Pending bits keep accumulating. On iret, go to IDLE.
- After iret, a still-eligible source is requested again via IDLE→REQ. There is no IRET→REQ shortcut.
- iret outside SERVICE is ignored. intr_ack outside REQ is ignored.
- The handler address is the same for all sources. Software reads intr_id through the R_IO path to dispatch; that mux lives outside this block.

## Timing
- Reset values: intr_req=0, intr_id=0, intr_handler=0, epc=0, in_service=0, pending=0, mask=0, state=IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Request latency: irq_src high in cycle t → pending set at edge t → state REQ at edge t+1 → intr_req=1 in cycle t+2.
- Acceptance: intr_ack in cycle a → intr_req=0 and in_service=1 from cycle a+1. epc is valid from a+1.
- Return: iret in cycle r → in_service=0 at r+1. A pending eligible source gives intr_req=1 at r+2.
- Reset asserted mid-operation (any state) returns the block to IDLE immediately. The saved epc is lost.

## Structure
- Add to lib_cpu package:
  - typedef enum INTR_STATE {INTR_IDLE, INTR_REQ, INTR_SERVICE}.
  - Localparams SRC_UART_RX=0, SRC_TIMER=1.
  - INTR_NUM_SRC=4.
- One sub-module, intr_prio_enc: combinational lowest-index priority encoder producing {valid, id} from eligible.
- mother_board instantiates intr_ctrl next to cpu.
  - cpu drives w_intr, iret, intr_ack and pc_next from its decode/execute stages.

## Test plan
- Single source: mask=4'b0010, pulse irq_src[1] at cycle 5 → intr_req=1 at cycle 7, intr_id=1. Ack at cycle 9 with pc_next=32'h0000_0040 → epc=32'h40, in_service=1 at cycle 10, pending[1]=0.
- Priority: mask=4'b1111, irq_src=4'b1010 in one cycle → intr_id=1. After ack and then iret → second request with intr_id=3.
- Masking: pulse irq_src[2] with mask=0 → no request. Write mask=4'b0100 → intr_req=1 two cycles after the write.
- Mask cleared during REQ: REQ for id 0, then W_INTR mask=0 → intr_req=0 next cycle and state IDLE; pending[0] is still 1.
- Simultaneous set and clear: irq_src[0] high in the same cycle as intr_ack for id 0 → pending[0]=1 after the ack. After iret a re-request occurs with intr_id=0.
- Reset mid-service: pull reset low in SERVICE → all outputs are 0 asynchronously. After release, no request until a new irq_src with mask set.
